// File: rtl/calc_pkg.sv
// Shared calculator definitions: operator codes, key classes, scanner FSM states
// and the keypad row/column decode used by the scanner and by control benches.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        KeyDigit,
        KeyOper,
        KeyBksp,
        KeyEquals
    } key_class_e;

    typedef enum logic [1:0] {
        StScan,
        StPressDb,
        StEmit,
        StReleaseDb
    } scan_state_e;

    // For KeyOper, value[1:0] carries the operator code.
    typedef struct packed {
        key_class_e cls;
        logic [3:0] value;
    } key_t;

    // Index of the lowest-numbered low (pressed) row; 0 when none is low.
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Layout: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = * 0 # D.
    function automatic key_t decode_key(input logic [1:0] r, input logic [1:0] c);
        key_t k;
        k.cls   = KeyDigit;
        k.value = 4'd0;
        if (c == 2'd3) begin
            k.cls   = KeyOper;
            k.value = {2'b00, r};
        end else if (r == 2'd3) begin
            unique case (c)
                2'd0:    k.cls   = KeyBksp;
                2'd1:    k.value = 4'd0;
                default: k.cls   = KeyEquals;
            endcase
        end else begin
            k.value = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end
        return k;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs, parameterised in width.
module sync_2ff #(
    parameter int unsigned      Width      = 1,
    parameter logic [Width-1:0] ResetValue = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= ResetValue;
            sync_q <= ResetValue;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column rotation, press/release debounce and
// single-cycle key event strobes for the calculator control stage.
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       dig_in,
    output logic       bksp_in,
    output logic       op_in,
    output logic       eq_in,
    output logic [3:0] digit,
    output logic [1:0] op_code
);

    localparam int unsigned      SlotW    = $clog2(SCAN_DIV);
    localparam int unsigned      DbW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
    localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);

    logic [3:0] row_s;

    sync_2ff #(
        .Width      (4),
        .ResetValue (4'hF)
    ) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d     (row),
        .q     (row_s)
    );

    scan_state_e      state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [DbW-1:0]   db_q, db_d;
    logic [3:0]       row_lat_q, row_lat_d;
    logic             dig_q, dig_d, bksp_q, bksp_d, op_q, op_d, eq_q, eq_d;
    logic [3:0]       digit_q, digit_d;
    logic [1:0]       op_code_q, op_code_d;
    key_t             key;

    // col_idx_q stays frozen outside StScan, so it doubles as the latched column.
    assign key = decode_key(lowest_low_row(row_lat_q), col_idx_q);

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        slot_d    = slot_q;
        db_d      = db_q;
        row_lat_d = row_lat_q;
        digit_d   = digit_q;
        op_code_d = op_code_q;
        dig_d     = 1'b0;
        bksp_d    = 1'b0;
        op_d      = 1'b0;
        eq_d      = 1'b0;

        unique case (state_q)
            StScan: begin
                if (slot_q == SlotLast) begin
                    slot_d = '0;
                    if (row_s != 4'hF) begin
                        row_lat_d = row_s;
                        db_d      = '0;
                        state_d   = StPressDb;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end else begin
                    slot_d = slot_q + 1'b1;
                end
            end
            StPressDb: begin
                if (row_s != row_lat_q) begin
                    db_d      = '0;
                    slot_d    = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = StScan;
                end else if (db_q == DbLast) begin
                    // Strobes register on this edge so they are high during StEmit.
                    db_d    = '0;
                    state_d = StEmit;
                    unique case (key.cls)
                        KeyDigit: begin
                            dig_d   = 1'b1;
                            digit_d = key.value;
                        end
                        KeyOper: begin
                            op_d      = 1'b1;
                            op_code_d = key.value[1:0];
                        end
                        KeyBksp: begin
                            dig_d  = 1'b1;
                            bksp_d = 1'b1;
                        end
                        KeyEquals: eq_d = 1'b1;
                    endcase
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            StEmit: begin
                db_d    = '0;
                state_d = StReleaseDb;
            end
            StReleaseDb: begin
                if (row_s != 4'hF) begin
                    db_d = '0;
                end else if (db_q == DbLast) begin
                    db_d      = '0;
                    slot_d    = '0;
                    col_idx_d = col_idx_q + 2'd1;
                    state_d   = StScan;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StScan;
            col_idx_q <= 2'd0;
            slot_q    <= '0;
            db_q      <= '0;
            row_lat_q <= 4'hF;
            dig_q     <= 1'b0;
            bksp_q    <= 1'b0;
            op_q      <= 1'b0;
            eq_q      <= 1'b0;
            digit_q   <= 4'd0;
            op_code_q <= OP_ADD;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            slot_q    <= slot_d;
            db_q      <= db_d;
            row_lat_q <= row_lat_d;
            dig_q     <= dig_d;
            bksp_q    <= bksp_d;
            op_q      <= op_d;
            eq_q      <= eq_d;
            digit_q   <= digit_d;
            op_code_q <= op_code_d;
        end
    end

    assign col     = ~(4'b0001 << col_idx_q);
    assign dig_in  = dig_q;
    assign bksp_in = bksp_q;
    assign op_in   = op_q;
    assign eq_in   = eq_q;
    assign digit   = digit_q;
    assign op_code = op_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a timeline model predicts every output each cycle,
// and directed key presses are pinned with hand-computed expectations.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic       dig_in, bksp_in, op_in, eq_in;
    logic [3:0] digit;
    logic [1:0] op_code;

    keypad_scanner #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .row     (row),
        .col     (col),
        .dig_in  (dig_in),
        .bksp_in (bksp_in),
        .op_in   (op_in),
        .eq_in   (eq_in),
        .digit   (digit),
        .op_code (op_code)
    );

    always #5 clock = ~clock;

    // Physical keypad: the held key pulls its row low only while its column is driven.
    logic key_down = 1'b0;
    int   key_r = 0;
    int   key_c = 0;
    assign row = (key_down && col[key_c] == 1'b0) ? ~(4'b0001 << key_r) : 4'hF;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- timeline model ----------------
    typedef enum int {MScan, MPress, MEmit, MRelease} mmode_e;
    string  keymap [4] = '{"123A", "456B", "789C", "*0#D"};
    mmode_e m_mode = MScan;
    logic   m_valid = 1'b0;
    int     k_edge = 0;
    int     m_s = 0, m_c0 = 0, m_ps = 0, m_q = 0, m_col = 0;
    logic [3:0] m_pat, rs1, rs2, rs_now;
    logic [3:0] exp_col, exp_digit;
    logic [1:0] exp_opc;
    logic       exp_dig, exp_bksp, exp_op, exp_eq;
    int     m_n_dig = 0, m_n_op = 0, m_n_eq = 0;

    function automatic int low_row(input logic [3:0] p);
        for (int i = 0; i < 4; i++) if (!p[i]) return i;
        return 0;
    endfunction

    task automatic model_emit();
        string s;
        byte   ch;
        s  = keymap[low_row(m_pat)];
        ch = s[m_col];
        if (ch >= "0" && ch <= "9") begin
            exp_dig = 1'b1; exp_digit = 4'(ch - "0"); m_n_dig++;
        end else if (ch >= "A" && ch <= "D") begin
            exp_op = 1'b1; exp_opc = 2'(ch - "A"); m_n_op++;
        end else if (ch == "*") begin
            exp_dig = 1'b1; exp_bksp = 1'b1; m_n_dig++;
        end else begin
            exp_eq = 1'b1; m_n_eq++;
        end
    endtask

    initial begin : model
        int cidx;
        forever begin
            @(posedge clock);
            k_edge++;
            rs_now   = rs2;
            exp_dig  = 1'b0;
            exp_bksp = 1'b0;
            exp_op   = 1'b0;
            exp_eq   = 1'b0;
            if (reset) begin
                rs1 = 4'hF; rs2 = 4'hF;
                m_mode = MScan; m_s = k_edge; m_c0 = 0;
                exp_digit = 4'd0; exp_opc = 2'd0;
                m_valid = 1'b1;
            end else begin
                rs2 = rs1;
                rs1 = row;
                if (m_valid) begin
                    case (m_mode)
                        MScan: begin
                            if ((k_edge - 1 - m_s) % SD == SD - 1 && rs_now != 4'hF) begin
                                m_col  = (m_c0 + (k_edge - 1 - m_s) / SD) % 4;
                                m_pat  = rs_now;
                                m_ps   = k_edge;
                                m_mode = MPress;
                            end
                        end
                        MPress: begin
                            if (rs_now != m_pat) begin
                                m_mode = MScan; m_s = k_edge; m_c0 = m_col + 1;
                            end else if (k_edge - m_ps == DB) begin
                                m_mode = MEmit;
                                model_emit();
                            end
                        end
                        MEmit: begin
                            m_mode = MRelease; m_q = k_edge;
                        end
                        default: begin
                            if (rs_now != 4'hF) m_q = k_edge;
                            else if (k_edge - m_q == DB) begin
                                m_mode = MScan; m_s = k_edge; m_c0 = m_col + 1;
                            end
                        end
                    endcase
                end
            end
            cidx    = (m_mode == MScan) ? (m_c0 + (k_edge - m_s) / SD) % 4 : m_col;
            exp_col = ~(4'b0001 << cidx);
        end
    end

    // ---------------- per-cycle compare and event monitor ----------------
    int obs_dig = 0, obs_bksp = 0, obs_op = 0, obs_eq = 0, obs_bad = 0;
    logic [3:0] obs_digit = 4'd0, obs_bksp_digit = 4'd0;
    logic [1:0] obs_opc = 2'd0;

    initial begin : compare
        forever begin
            @(negedge clock);
            if (m_valid) begin
                n_tests++;
                if ({col, dig_in, bksp_in, op_in, eq_in, digit, op_code} !==
                    {exp_col, exp_dig, exp_bksp, exp_op, exp_eq, exp_digit, exp_opc}) begin
                    n_fail++;
                    $display("FAIL cycle@%0t: got col=%b dig=%b bksp=%b op=%b eq=%b digit=%0d opc=%b; expected col=%b dig=%b bksp=%b op=%b eq=%b digit=%0d opc=%b",
                             $time, col, dig_in, bksp_in, op_in, eq_in, digit, op_code,
                             exp_col, exp_dig, exp_bksp, exp_op, exp_eq, exp_digit, exp_opc);
                end
                if (dig_in === 1'b1) begin obs_dig++; obs_digit = digit; end
                if (bksp_in === 1'b1) begin
                    obs_bksp++; obs_bksp_digit = digit;
                    if (dig_in !== 1'b1) obs_bad++;
                end
                if (op_in === 1'b1) begin obs_op++; obs_opc = op_code; end
                if (eq_in === 1'b1) obs_eq++;
                if (int'(dig_in === 1'b1) + int'(op_in === 1'b1) + int'(eq_in === 1'b1) > 1)
                    obs_bad++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input int r, input int c, input int hold, input int gap);
        key_r = r; key_c = c; key_down = 1'b1;
        cycles(hold);
        key_down = 1'b0;
        cycles(gap);
    endtask

    initial begin : stimulus
        logic [3:0] col_seq [5];
        int d0, b0, o0, e0, md0;
        col_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

        cycles(2);
        reset = 1'b0;
        check("reset col", int'(col), 4'b1110);
        check("reset strobes", int'({dig_in, bksp_in, op_in, eq_in}), 0);
        check("reset digit", int'(digit), 0);
        check("reset op_code", int'(op_code), 0);
        for (int i = 0; i <= 16; i++) begin
            if (i % 4 == 0) check($sformatf("scan col step %0d", i / 4), int'(col),
                                  int'(col_seq[i / 4]));
            if (i < 16) cycles(1);
        end

        // Clean "5"
        d0 = obs_dig; b0 = obs_bksp; o0 = obs_op; md0 = m_n_dig;
        press(1, 1, 40, 30);
        check("5 dig pulses", obs_dig - d0, 1);
        check("5 digit", int'(obs_digit), 5);
        check("5 no bksp", obs_bksp - b0, 0);
        check("5 no op", obs_op - o0, 0);
        check("5 model events", m_n_dig - md0, 1);

        // Bouncy "C"
        o0 = obs_op;
        key_r = 2; key_c = 3;
        for (int i = 0; i < 20; i++) begin
            key_down = ((i / 3) % 2 == 0);
            cycles(1);
        end
        check("C quiet during bounce", obs_op - o0, 0);
        key_down = 1'b1;
        cycles(40);
        key_down = 1'b0;
        cycles(30);
        check("C op pulses", obs_op - o0, 1);
        check("C op_code", int'(obs_opc), 2);

        // Backspace "*"
        d0 = obs_dig; b0 = obs_bksp;
        press(3, 0, 40, 30);
        check("bksp dig pulses", obs_dig - d0, 1);
        check("bksp pulses", obs_bksp - b0, 1);
        check("bksp keeps digit", int'(obs_bksp_digit), 5);

        // "#" then "D"
        d0 = obs_dig; o0 = obs_op; e0 = obs_eq;
        press(3, 2, 40, 30);
        check("eq pulses", obs_eq - e0, 1);
        press(3, 3, 40, 30);
        check("D op pulses", obs_op - o0, 1);
        check("D op_code", int'(obs_opc), 3);
        check("#D no dig", obs_dig - d0, 0);

        // Reset during press debounce of "7"
        d0 = obs_dig;
        key_r = 2; key_c = 0; key_down = 1'b1;
        for (int i = 0; i < 100 && m_mode != MPress; i++) cycles(1);
        check("7 press reached", int'(m_mode == MPress), 1);
        cycles(3);
        reset = 1'b1;
        cycles(1);
        check("7 reset col", int'(col), 4'b1110);
        cycles(1);
        reset = 1'b0;
        check("7 no strobe through reset", obs_dig - d0, 0);
        check("7 digit cleared", int'(digit), 0);
        cycles(60);
        key_down = 1'b0;
        cycles(30);
        check("7 dig pulses", obs_dig - d0, 1);
        check("7 digit", int'(obs_digit), 7);

        check("strobe exclusivity", obs_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
